// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush/freeze control, fetch and bubble performance
// counters, and a consecutive-freeze timeout flag.
module if_id_reg #(
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [WIDTH-1:0] instruction_in,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] instruction,
    output logic             valid,
    output logic [CNT_W-1:0] fetched_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             stall_timeout
);

    localparam int FC_W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(STALL_MAX);

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_FREEZE,
        ACT_FLUSH
    } action_t;

    action_t         action;
    logic [FC_W-1:0] freeze_cnt;
    logic [FC_W-1:0] freeze_cnt_nxt;

    // Flush wins over freeze, freeze wins over load.
    always_comb begin
        action = ACT_LOAD;
        if (flush) begin
            action = ACT_FLUSH;
        end else if (freeze) begin
            action = ACT_FREEZE;
        end
    end

    // Consecutive-freeze count; any load or flush restarts it from zero.
    always_comb begin
        freeze_cnt_nxt = '0;
        if (action == ACT_FREEZE) begin
            freeze_cnt_nxt = (freeze_cnt >= FC_MAX) ? FC_MAX : freeze_cnt + FC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC            <= '0;
            instruction   <= '0;
            valid         <= 1'b0;
            fetched_cnt   <= '0;
            bubble_cnt    <= '0;
            freeze_cnt    <= '0;
            stall_timeout <= 1'b0;
        end else begin
            freeze_cnt    <= freeze_cnt_nxt;
            stall_timeout <= (freeze_cnt_nxt >= FC_MAX);

            if (action == ACT_LOAD) begin
                PC          <= PC_in;
                instruction <= instruction_in;
                valid       <= 1'b1;
                if (fetched_cnt != '1) begin
                    fetched_cnt <= fetched_cnt + CNT_W'(1);
                end
            end else begin
                if (action == ACT_FLUSH) begin
                    PC          <= '0;
                    instruction <= '0;
                    valid       <= 1'b0;
                end
                if (bubble_cnt != '1) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: default-parameter instance plus a CNT_W=4 instance
// sharing the same stimulus for counter saturation.
module tb_if_id_reg;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic [31:0] PC_in;
    logic [31:0] instruction_in;

    logic [31:0] PC;
    logic [31:0] instruction;
    logic        valid;
    logic [15:0] fetched_cnt;
    logic [15:0] bubble_cnt;
    logic        stall_timeout;

    logic [31:0] s_PC;
    logic [31:0] s_instruction;
    logic        s_valid;
    logic [3:0]  s_fetched_cnt;
    logic [3:0]  s_bubble_cnt;
    logic        s_stall_timeout;

    int passed;
    int total;

    if_id_reg #(.WIDTH(32), .CNT_W(16), .STALL_MAX(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .flush          (flush),
        .PC_in          (PC_in),
        .instruction_in (instruction_in),
        .PC             (PC),
        .instruction    (instruction),
        .valid          (valid),
        .fetched_cnt    (fetched_cnt),
        .bubble_cnt     (bubble_cnt),
        .stall_timeout  (stall_timeout)
    );

    if_id_reg #(.WIDTH(32), .CNT_W(4), .STALL_MAX(15)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .flush          (flush),
        .PC_in          (PC_in),
        .instruction_in (instruction_in),
        .PC             (s_PC),
        .instruction    (s_instruction),
        .valid          (s_valid),
        .fetched_cnt    (s_fetched_cnt),
        .bubble_cnt     (s_bubble_cnt),
        .stall_timeout  (s_stall_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got stuck, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; PC_in = '0; instruction_in = '0;
        #3;
        total++;
        if ({PC, instruction, valid, fetched_cnt, bubble_cnt, stall_timeout} !== '0)
            $display("FAIL reset_state: got PC=%h instr=%h valid=%b fc=%0d bc=%0d to=%b, required all 0",
                     PC, instruction, valid, fetched_cnt, bubble_cnt, stall_timeout);
        else passed++;
        #9;
        rst = 1'b0;
    endtask

    task automatic test_load();
        PC_in = 32'h4; instruction_in = 32'h8C22_0000;
        step();
        total++;
        if (PC !== 32'h4 || instruction !== 32'h8C22_0000 || valid !== 1'b1)
            $display("FAIL load_data: got PC=%h instr=%h valid=%b, required 00000004 8c220000 1",
                     PC, instruction, valid);
        else passed++;
        total++;
        if (fetched_cnt !== 16'd1 || bubble_cnt !== 16'd0 || stall_timeout !== 1'b0)
            $display("FAIL load_counters: got fc=%0d bc=%0d to=%b, required 1 0 0",
                     fetched_cnt, bubble_cnt, stall_timeout);
        else passed++;
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            PC_in = 32'h100 + 32'(i); instruction_in = 32'hDEAD_0000 + 32'(i);
            step();
        end
        total++;
        if (PC !== 32'h4 || instruction !== 32'h8C22_0000 || valid !== 1'b1)
            $display("FAIL freeze_hold: got PC=%h instr=%h valid=%b, required 00000004 8c220000 1",
                     PC, instruction, valid);
        else passed++;
        total++;
        if (bubble_cnt !== 16'd3 || fetched_cnt !== 16'd1 || stall_timeout !== 1'b0)
            $display("FAIL freeze_counters: got bc=%0d fc=%0d to=%b, required 3 1 0",
                     bubble_cnt, fetched_cnt, stall_timeout);
        else passed++;
    endtask

    task automatic test_flush_over_freeze();
        flush = 1'b1; freeze = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (PC !== 32'h0 || instruction !== 32'h0 || valid !== 1'b0)
            $display("FAIL flush_squash: got PC=%h instr=%h valid=%b, required 0 0 0",
                     PC, instruction, valid);
        else passed++;
        total++;
        if (bubble_cnt !== 16'd4 || fetched_cnt !== 16'd1)
            $display("FAIL flush_bubble_once: got bc=%0d fc=%0d, required 4 1", bubble_cnt, fetched_cnt);
        else passed++;
    endtask

    // Freeze counter was cleared by the flush above, so 15 more freeze edges are needed.
    task automatic test_timeout();
        freeze = 1'b1;
        repeat (14) step();
        total++;
        if (stall_timeout !== 1'b0)
            $display("FAIL timeout_14: got %b, required 0", stall_timeout);
        else passed++;
        step();
        total++;
        if (stall_timeout !== 1'b1)
            $display("FAIL timeout_15: got %b, required 1", stall_timeout);
        else passed++;
        step();
        total++;
        if (stall_timeout !== 1'b1 || bubble_cnt !== 16'd20)
            $display("FAIL timeout_16: got to=%b bc=%0d, required 1 20", stall_timeout, bubble_cnt);
        else passed++;
        freeze = 1'b0; PC_in = 32'h100; instruction_in = 32'h0000_1234;
        step();
        total++;
        if (stall_timeout !== 1'b0 || PC !== 32'h100 || instruction !== 32'h1234 || valid !== 1'b1
            || fetched_cnt !== 16'd2)
            $display("FAIL timeout_release: got to=%b PC=%h instr=%h valid=%b fc=%0d, required 0 00000100 00001234 1 2",
                     stall_timeout, PC, instruction, valid, fetched_cnt);
        else passed++;
    endtask

    task automatic test_flush_clears_freeze();
        freeze = 1'b1;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (14) step();
        total++;
        if (stall_timeout !== 1'b0 || valid !== 1'b0)
            $display("FAIL flush_clears_freeze: got to=%b valid=%b, required 0 0", stall_timeout, valid);
        else passed++;
        step();
        total++;
        if (stall_timeout !== 1'b1)
            $display("FAIL flush_then_timeout: got %b, required 1", stall_timeout);
        else passed++;
        freeze = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [4] = '{32'h0000_0200, 32'h0000_0204, 32'hFFFF_FFFC, 32'hA5A5_5A5A};
        for (int i = 0; i < 4; i++) begin
            PC_in = pcs[i]; instruction_in = ~pcs[i];
            step();
            total++;
            if (PC !== pcs[i] || instruction !== ~pcs[i] || valid !== 1'b1)
                $display("FAIL back_to_back_%0d: got PC=%h instr=%h valid=%b, required %h %h 1",
                         i, PC, instruction, valid, pcs[i], ~pcs[i]);
            else passed++;
        end
        PC_in = 32'h1111_1111; instruction_in = 32'h2222_2222;
        #2;
        total++;
        if (PC !== 32'hA5A5_5A5A || instruction !== 32'h5A5A_A5A5)
            $display("FAIL no_comb_path: got PC=%h instr=%h, required a5a55a5a 5a5aa5a5", PC, instruction);
        else passed++;
    endtask

    task automatic test_async_reset();
        PC_in = 32'h300; instruction_in = 32'h300;
        repeat (3) step();
        freeze = 1'b1;
        step();
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({PC, instruction, valid, fetched_cnt, bubble_cnt, stall_timeout} !== '0)
            $display("FAIL async_reset: got PC=%h instr=%h valid=%b fc=%0d bc=%0d to=%b, required all 0",
                     PC, instruction, valid, fetched_cnt, bubble_cnt, stall_timeout);
        else passed++;
        freeze = 1'b0;
        repeat (2) step();
        flush = 1'b1;
        step();
        total++;
        if ({PC, instruction, valid, fetched_cnt, bubble_cnt, stall_timeout} !== '0)
            $display("FAIL reset_hold: got PC=%h instr=%h valid=%b fc=%0d bc=%0d, required all 0",
                     PC, instruction, valid, fetched_cnt, bubble_cnt);
        else passed++;
        #2;
        flush = 1'b0;
        rst = 1'b0;
        PC_in = 32'h40; instruction_in = 32'h0042_0042;
        step();
        total++;
        if (fetched_cnt !== 16'd1 || bubble_cnt !== 16'd0 || PC !== 32'h40 || valid !== 1'b1)
            $display("FAIL post_reset_load: got fc=%0d bc=%0d PC=%h valid=%b, required 1 0 00000040 1",
                     fetched_cnt, bubble_cnt, PC, valid);
        else passed++;
    endtask

    task automatic test_saturation();
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        freeze = 1'b0; flush = 1'b0;
        repeat (20) step();
        total++;
        if (s_fetched_cnt !== 4'd15)
            $display("FAIL fetched_saturate: got %0d, required 15", s_fetched_cnt);
        else passed++;
        total++;
        if (fetched_cnt !== 16'd20)
            $display("FAIL fetched_wide: got %0d, required 20", fetched_cnt);
        else passed++;
        freeze = 1'b1;
        repeat (18) step();
        total++;
        if (s_bubble_cnt !== 4'd15 || bubble_cnt !== 16'd18)
            $display("FAIL bubble_saturate: got narrow=%0d wide=%0d, required 15 18", s_bubble_cnt, bubble_cnt);
        else passed++;
        freeze = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_load();
        test_freeze();
        test_flush_over_freeze();
        test_timeout();
        test_flush_clears_freeze();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: width of PC and instruction datapaths.
- REQ-002 SHALL have parameter CNT_W, default 16: width of each performance counter.
- REQ-003 SHALL have parameter STALL_MAX, default 15: consecutive freeze cycles that raise stall_timeout.
- REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
- REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
- REQ-006 SHALL have port freeze  input  1  hold current contents (hazard stall from ID).
- REQ-007 SHALL have port flush  input  1  squash current contents (branch taken in a later stage).
- REQ-008 SHALL have port PC_in  input  WIDTH  PC value produced by the fetch stage.
- REQ-009 SHALL have port instruction_in  input  WIDTH  instruction word produced by the fetch stage.
- REQ-010 SHALL have port PC  output  WIDTH  registered PC presented to decode.
- REQ-011 SHALL have port instruction  output  WIDTH  registered instruction presented to decode.
- REQ-012 SHALL have port valid  output  1  high when instruction holds a real fetched word, not a bubble.
- REQ-013 SHALL have port fetched_cnt  output  CNT_W  number of load cycles since reset.
- REQ-014 SHALL have port bubble_cnt  output  CNT_W  number of flush or freeze cycles since reset.
- REQ-015 SHALL have port stall_timeout  output  1  high while consecutive freeze count >= STALL_MAX.

Function
- REQ-016 SHALL apply per-edge priority: flush > freeze > load.
- REQ-017 Flush: PC <= 0, instruction <= 0 (NOP), valid <= 0, regardless of freeze.
- REQ-018 Freeze without flush: PC, instruction, valid hold their values.
- REQ-019 Load (neither asserted): PC <= PC_in, instruction <= instruction_in, valid <= 1; values stored unmodified, no arithmetic.
- REQ-020 Latency SHALL be exactly one cycle from PC_in/instruction_in to PC/instruction; outputs are register outputs only, no combinational input-to-output path.
- REQ-021 fetched_cnt SHALL increment by 1 on each load edge; saturate at 2^CNT_W-1, no wrap.
- REQ-022 bubble_cnt SHALL increment by 1 on each edge with flush or freeze high (flush and freeze together counts once); saturate at 2^CNT_W-1.
- REQ-023 SHALL keep an internal consecutive-freeze counter: +1 on each freeze-only edge (saturating at STALL_MAX), cleared to 0 on any load or flush edge.
- REQ-024 stall_timeout SHALL be registered, high from the edge where the freeze counter reaches STALL_MAX until the edge where it clears.
- REQ-025 Flush during an ongoing freeze SHALL squash contents and clear the freeze counter on the same edge.

Reset
- REQ-026 rst high SHALL immediately, without a clock edge, force PC=0, instruction=0, valid=0, fetched_cnt=0, bubble_cnt=0, freeze counter=0, stall_timeout=0.
- REQ-027 While rst is high, all state SHALL hold reset values regardless of clk, freeze, flush.
- REQ-028 Reset asserted mid-freeze or mid-flush SHALL abort the operation; the first edge after rst release follows normal priority.

Verification
- REQ-029 Load: PC_in=0x4, instruction_in=0x8C220000, freeze=flush=0, one edge -> PC=0x4, instruction=0x8C220000, valid=1, fetched_cnt=1.
- REQ-030 Freeze: after REQ-029, freeze=1 for 3 edges with changing inputs -> outputs unchanged, bubble_cnt=3, fetched_cnt=1.
- REQ-031 Flush beats freeze: flush=1, freeze=1, one edge -> PC=0, instruction=0, valid=0, bubble_cnt increments by exactly 1.
- REQ-032 Timeout: STALL_MAX=15, freeze=1 for 15 edges -> stall_timeout=1 after 15th edge; freeze=0 one edge -> stall_timeout=0, new data loaded.
- REQ-033 Async reset: after several loads, assert rst between clock edges -> all outputs 0 before next edge; release, one load -> fetched_cnt=1.
- REQ-034 Saturation: CNT_W=4, 20 load edges -> fetched_cnt=15, no wrap to 0.
